// File: rtl/ranc_tick_sequencer.sv
// Host-side tick sequencer for the RANC grid: buffers host packets, feeds core 0's west port,
// waits for quiescence, fires the global tick, then waits for spikes to settle and reports counts.
module ranc_tick_sequencer #(
  parameter int PACKET_WIDTH  = 30,
  parameter int FIFO_DEPTH    = 16,
  parameter int DRAIN_CYCLES  = 32,
  parameter int SETTLE_CYCLES = 1024,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_wr_en,
  input  logic [PACKET_WIDTH-1:0] host_packet,
  output logic                    host_full,
  input  logic                    host_tick_req,
  input  logic                    err_clear,
  output logic                    busy,
  output logic                    tick_done,
  output logic [PACKET_WIDTH-1:0] grid_packet_in,
  output logic                    grid_input_buffer_empty,
  input  logic                    grid_ren,
  input  logic                    grid_packet_out_valid,
  input  logic                    grid_token_controller_error,
  input  logic                    grid_scheduler_error,
  output logic                    tick,
  output logic [COUNT_WIDTH-1:0]  tick_count,
  output logic [COUNT_WIDTH-1:0]  spike_count,
  output logic [3:0]              error_flags
);

  // state    | meaning
  // S_IDLE   | waiting for host_tick_req, host may load the FIFO
  // S_INJECT | FIFO head presented to the grid until the FIFO runs dry
  // S_DRAIN  | waiting for DRAIN_CYCLES consecutive cycles without a spike
  // S_TICK   | one-cycle global tick, spike accumulator restarted
  // S_SETTLE | fixed settle window, then the same idle rule as S_DRAIN
  // S_DONE   | publish counts, pulse tick_done
  typedef enum logic [2:0] {S_IDLE, S_INJECT, S_DRAIN, S_TICK, S_SETTLE, S_DONE} state_t;

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ICW = $clog2(DRAIN_CYCLES + 1);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [AW:0]      FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [ICW-1:0]   IDLE_LAST     = ICW'(DRAIN_CYCLES - 1);
  localparam logic [SCW-1:0]   SETTLE_END    = SCW'(SETTLE_CYCLES);

  state_t state, state_next;

  logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic          wr_accept, wr_drop, pop, underflow;

  logic [ICW-1:0]         idle_cnt;
  logic [SCW-1:0]         settle_cnt;
  logic                   settle_done, quiet, idle_phase;
  logic [COUNT_WIDTH-1:0] spike_acc, spike_acc_inc;

  assign fifo_empty              = (fifo_cnt == '0);
  assign fifo_full               = (fifo_cnt == FIFO_FULL_CNT);
  assign host_full               = fifo_full || busy;
  assign grid_input_buffer_empty = fifo_empty || (state != S_INJECT);
  assign grid_packet_in          = mem[rd_ptr];

  assign wr_accept = host_wr_en && !host_full;
  assign wr_drop   = host_wr_en && host_full;
  assign pop       = grid_ren && !grid_input_buffer_empty;
  assign underflow = grid_ren && grid_input_buffer_empty;

  assign settle_done = (settle_cnt == SETTLE_END);
  assign idle_phase  = (state == S_DRAIN) || ((state == S_SETTLE) && settle_done);
  assign quiet       = !grid_packet_out_valid && (idle_cnt == IDLE_LAST);

  // Saturating view of the accumulator including this cycle's spike.
  assign spike_acc_inc = (grid_packet_out_valid && (spike_acc != '1)) ? spike_acc + 1'b1 : spike_acc;

  assign tick      = (state == S_TICK);
  assign tick_done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_accept) begin
        mem[wr_ptr] <= host_packet;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (host_tick_req) state_next = S_INJECT;
      S_INJECT: if (fifo_empty || (pop && fifo_cnt == 1)) state_next = S_DRAIN;
      S_DRAIN:  if (quiet) state_next = S_TICK;
      S_TICK:   state_next = S_SETTLE;
      S_SETTLE: if (settle_done && quiet) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Idle counter restarts whenever a quiescence window is not being measured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      if (idle_phase && !grid_packet_out_valid) idle_cnt <= idle_cnt + 1'b1;
      else                                      idle_cnt <= '0;
      if (state == S_TICK)                          settle_cnt <= '0;
      else if ((state == S_SETTLE) && !settle_done) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_acc   <= '0;
      spike_count <= '0;
      tick_count  <= '0;
    end else begin
      if (state == S_TICK) spike_acc <= {{(COUNT_WIDTH-1){1'b0}}, grid_packet_out_valid};
      else                 spike_acc <= spike_acc_inc;
      if (state == S_DONE) begin
        spike_count <= spike_acc_inc;
        tick_count  <= tick_count + 1'b1;
      end
    end
  end

  // A flag raised in the same cycle as err_clear survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_flags <= '0;
    else     error_flags <= (err_clear ? 4'b0000 : error_flags)
                            | {grid_scheduler_error, grid_token_controller_error, underflow, wr_drop};
  end

endmodule

// File: tb/tb_ranc_tick_sequencer.sv
// Directed bench for ranc_tick_sequencer with short drain/settle windows and a 4-entry FIFO.
module tb_ranc_tick_sequencer;
  localparam int PW = 30;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_wr_en, host_tick_req, err_clear, grid_ren;
  logic [PW-1:0] host_packet;
  logic          grid_packet_out_valid, grid_token_controller_error, grid_scheduler_error;
  logic          host_full, busy, tick_done, grid_input_buffer_empty, tick;
  logic [PW-1:0] grid_packet_in;
  logic [CW-1:0] tick_count, spike_count;
  logic [3:0]    error_flags;

  logic [PW-1:0] pk [5];
  int checks = 0;
  int errors = 0;
  int n, pulses, ticks;

  ranc_tick_sequencer #(
    .PACKET_WIDTH(PW), .FIFO_DEPTH(4), .DRAIN_CYCLES(4), .SETTLE_CYCLES(8), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_packet(host_packet), .host_full(host_full),
    .host_tick_req(host_tick_req), .err_clear(err_clear), .busy(busy), .tick_done(tick_done),
    .grid_packet_in(grid_packet_in), .grid_input_buffer_empty(grid_input_buffer_empty),
    .grid_ren(grid_ren), .grid_packet_out_valid(grid_packet_out_valid),
    .grid_token_controller_error(grid_token_controller_error),
    .grid_scheduler_error(grid_scheduler_error),
    .tick(tick), .tick_count(tick_count), .spike_count(spike_count), .error_flags(error_flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int budget, output int cnt);
    cnt = 0;
    while (!tick && cnt < budget) begin step(); cnt++; end
    check_eq("tick_seen", {31'b0, tick}, 32'd1);
  endtask

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    while (!tick_done && cnt < budget) begin step(); cnt++; end
    check_eq("done_seen", {31'b0, tick_done}, 32'd1);
  endtask

  task automatic finish_tick(input string tag);
    int c;
    wait_tick(20, c);
    check_eq({tag, "_drain_len"}, c, 32'd4);
    step();
    check_eq({tag, "_tick_1cyc"}, {31'b0, tick}, 32'd0);
    wait_done(40, c);
    check_eq({tag, "_settle_len"}, c, 32'd12);
    step();
  endtask

  initial begin
    pk[0] = 30'h1234_5678; pk[1] = 30'h0abc_def0; pk[2] = 30'h3fff_0001;
    pk[3] = 30'h2000_0aaa; pk[4] = 30'h0555_5555;
    rst = 1'b1; host_wr_en = 0; host_tick_req = 0; err_clear = 0; grid_ren = 0;
    host_packet = '0; grid_packet_out_valid = 0;
    grid_token_controller_error = 0; grid_scheduler_error = 0;
    step(); step();
    rst = 1'b0;
    #1;
    check_eq("rst_empty", {31'b0, grid_input_buffer_empty}, 32'd1);
    check_eq("rst_full", {31'b0, host_full}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_tick", {31'b0, tick}, 32'd0);
    check_eq("rst_done", {31'b0, tick_done}, 32'd0);
    check_eq("rst_tcnt", tick_count, 32'd0);
    check_eq("rst_scnt", spike_count, 32'd0);
    check_eq("rst_flags", error_flags, 32'd0);
    check_eq("rst_pkt", grid_packet_in, 32'd0);

    // 1: three packets injected in order, then tick and done
    for (int i = 0; i < 3; i++) begin
      host_wr_en = 1; host_packet = pk[i]; step();
    end
    host_wr_en = 0;
    check_eq("t1_not_full", {31'b0, host_full}, 32'd0);
    host_tick_req = 1; step(); host_tick_req = 0;
    check_eq("t1_busy", {31'b0, busy}, 32'd1);
    check_eq("t1_full_busy", {31'b0, host_full}, 32'd1);
    grid_ren = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t1_pkt", grid_packet_in, pk[i]);
      check_eq("t1_present", {31'b0, grid_input_buffer_empty}, 32'd0);
      step();
    end
    grid_ren = 0;
    check_eq("t1_empty", {31'b0, grid_input_buffer_empty}, 32'd1);
    finish_tick("t1");
    check_eq("t1_tcnt", tick_count, 32'd1);
    check_eq("t1_scnt", spike_count, 32'd0);
    check_eq("t1_idle", {31'b0, busy}, 32'd0);
    check_eq("t1_flags", error_flags, 32'd0);

    // 2: overflow drops the fifth write
    for (int i = 0; i < 4; i++) begin
      host_wr_en = 1; host_packet = pk[i]; step();
    end
    check_eq("t2_full", {31'b0, host_full}, 32'd1);
    host_packet = pk[4]; step(); host_wr_en = 0;
    check_eq("t2_ovf", error_flags, 32'h1);
    err_clear = 1; step(); err_clear = 0;
    check_eq("t2_clear", error_flags, 32'h0);
    host_tick_req = 1; step(); host_tick_req = 0;
    grid_ren = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_pkt", grid_packet_in, pk[i]);
      step();
    end
    grid_ren = 0;
    check_eq("t2_drained", {31'b0, grid_input_buffer_empty}, 32'd1);
    finish_tick("t2");
    check_eq("t2_tcnt", tick_count, 32'd2);
    check_eq("t2_flags", error_flags, 32'h0);

    // 3: spikes during settle; quiescence counts from the last one
    host_tick_req = 1; step(); host_tick_req = 0;
    step();
    wait_tick(20, n);
    check_eq("t3_drain_len", n, 32'd4);
    step();
    grid_packet_out_valid = 1;
    repeat (5) step();
    grid_packet_out_valid = 0;
    repeat (2) step();
    grid_packet_out_valid = 1; step(); grid_packet_out_valid = 0;
    wait_done(20, n);
    check_eq("t3_quiet_len", n, 32'd4);
    step();
    check_eq("t3_scnt", spike_count, 32'd6);
    check_eq("t3_tcnt", tick_count, 32'd3);

    // 4: ren in IDLE is an underflow and pops nothing; grid error flags and clear priority
    host_wr_en = 1; host_packet = pk[4]; step(); host_wr_en = 0;
    grid_ren = 1; step(); grid_ren = 0;
    check_eq("t4_unf", error_flags, 32'h2);
    check_eq("t4_head", grid_packet_in, pk[4]);
    check_eq("t4_gated", {31'b0, grid_input_buffer_empty}, 32'd1);
    grid_token_controller_error = 1; step(); grid_token_controller_error = 0;
    check_eq("t4_tok", error_flags, 32'h6);
    err_clear = 1; grid_scheduler_error = 1; step(); err_clear = 0; grid_scheduler_error = 0;
    check_eq("t4_set_wins", error_flags, 32'h8);
    err_clear = 1; step(); err_clear = 0;
    check_eq("t4_clear", error_flags, 32'h0);

    // 5: reset during SETTLE aborts the tick
    host_tick_req = 1; step(); host_tick_req = 0;
    grid_ren = 1; step(); grid_ren = 0;
    wait_tick(20, n);
    check_eq("t5_drain_len", n, 32'd4);
    repeat (3) step();
    rst = 1; #1;
    check_eq("t5_busy", {31'b0, busy}, 32'd0);
    check_eq("t5_tick", {31'b0, tick}, 32'd0);
    check_eq("t5_tcnt", tick_count, 32'd0);
    check_eq("t5_full", {31'b0, host_full}, 32'd0);
    step(); rst = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_done) pulses++;
    end
    check_eq("t5_no_done", pulses, 32'd0);

    // 6: empty tick; repeated requests while busy are ignored
    host_tick_req = 1; step();
    check_eq("t6_fifo_empty", {31'b0, grid_input_buffer_empty}, 32'd1);
    check_eq("t6_busy", {31'b0, busy}, 32'd1);
    wait_tick(20, n);
    host_tick_req = 0;
    check_eq("t6_tick_lat", n, 32'd5);
    ticks = 1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tick) ticks++;
      if (tick_done) pulses++;
    end
    check_eq("t6_one_tick", ticks, 32'd1);
    check_eq("t6_one_done", pulses, 32'd1);
    check_eq("t6_tcnt", tick_count, 32'd1);
    check_eq("t6_idle", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
